// File: rtl/ad_ip_jesd204_tpl_dac_dma_buf.sv
// ---------------------------------------------------------------------------
// ad_ip_jesd204_tpl_dac_dma_buf
//
// Elastic buffer between a DMA AXI-stream source and the TPL DAC data input.
// Words from the DMA are stored in a 2**ADDR_WIDTH deep RAM. Playout starts
// once PREFILL words are held, or earlier if the DMA ends a short transfer
// with s_axis_last. From then on every dac_valid strobe returns one word on
// dac_ddata, registered, one cycle later. A strobe that finds the buffer
// empty returns zeros and raises dac_dunf for that cycle.
//
// Optional feature (compile-time macro DMA_BUF_CYCLIC_EN):
//   With cyclic=1 when playout is enabled, the buffer stores one transfer,
//   ending at the accepted s_axis_last or at full depth, then blocks further
//   writes and replays addresses 0..end for as long as enable stays high.
//   Without the macro the cyclic input is ignored.
//
// Ports:
//   clk           link clock, all logic on the rising edge
//   resetn        asynchronous active-low reset
//   enable        OR of the TPL channel enables; low stops and flushes
//   cyclic        request replay mode (only with DMA_BUF_CYCLIC_EN)
//   s_axis_*      DMA word stream (valid/ready/data/last)
//   dac_valid     TPL requests one word this cycle
//   dac_ddata     registered word to the TPL
//   dac_dunf      request served with zeros because the buffer was empty
//   level         words currently stored
// ---------------------------------------------------------------------------
module ad_ip_jesd204_tpl_dac_dma_buf #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int PREFILL    = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  cyclic,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_last,
  input  logic                  dac_valid,
  output logic [DATA_WIDTH-1:0] dac_ddata,
  output logic                  dac_dunf,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] ddata_q, ddata_d;
  logic                  dunf_q, dunf_d;

  logic                  cyc_q;
  logic                  end_latched_q;
  logic [ADDR_WIDTH-1:0] end_addr_q;
  logic                  end_evt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [PW-1:0]         level_w;
  logic [PW:0]           fill_cnt;
  logic                  full, empty, wr_en, fill_done;

`ifdef DMA_BUF_CYCLIC_EN
  logic                  cyc_d;
  logic                  end_latched_d;
  logic [ADDR_WIDTH-1:0] end_addr_d;

  // In replay mode the read pointer never consumes words, so the stored
  // count is simply the number of words written.
  assign level_w = cyc_q ? wr_ptr_q : (wr_ptr_q - rd_ptr_q);
  // The transfer ends at the accepted last word or when the final slot fills.
  assign end_evt = cyc_q && wr_en &&
                   (s_axis_last || (wr_ptr_q == PW'(DEPTH - 1)));
`else
  logic unused_cyclic;
  assign unused_cyclic = cyclic;
  assign cyc_q         = 1'b0;
  assign end_latched_q = 1'b0;
  assign end_addr_q    = '0;
  assign end_evt       = 1'b0;
  assign level_w       = wr_ptr_q - rd_ptr_q;
`endif

  assign full         = (level_w == PW'(DEPTH));
  assign empty        = (level_w == '0);
  assign s_axis_ready = (state_q != ST_IDLE) && !full && !end_latched_q;
  assign wr_en        = s_axis_valid && s_axis_ready;

  // Count including the word written this cycle, so RUN begins on the same
  // edge that stores the PREFILL-th word.
  assign fill_cnt  = {1'b0, level_w} + {{PW{1'b0}}, wr_en};
  assign fill_done = (fill_cnt >= (PW + 1)'(PREFILL)) || (wr_en && s_axis_last);

  assign rd_word   = mem[rd_ptr_q[ADDR_WIDTH-1:0]];

  assign dac_ddata = ddata_q;
  assign dac_dunf  = dunf_q;
  assign level     = level_w;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_axis_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ddata_d  = ddata_q;
    dunf_d   = 1'b0;
`ifdef DMA_BUF_CYCLIC_EN
    cyc_d         = cyc_q;
    end_latched_d = end_latched_q;
    end_addr_d    = end_addr_q;
    if (end_evt) begin
      end_latched_d = 1'b1;
      end_addr_d    = wr_ptr_q[ADDR_WIDTH-1:0];
    end
`endif

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (!enable) begin
      // Flush: whatever was stored or written this cycle is discarded.
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ddata_d  = '0;
`ifdef DMA_BUF_CYCLIC_EN
      cyc_d         = 1'b0;
      end_latched_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_FILL;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          ddata_d  = '0;
`ifdef DMA_BUF_CYCLIC_EN
          cyc_d = cyclic;
`endif
        end
        ST_FILL: begin
          ddata_d = '0;
          if (cyc_q) begin
            if (end_evt) state_d = ST_RUN;
          end else if (fill_done) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (dac_valid) begin
            if (cyc_q) begin
              ddata_d  = rd_word;
              rd_ptr_d = (rd_ptr_q[ADDR_WIDTH-1:0] == end_addr_q) ? '0
                                                                   : rd_ptr_q + PW'(1);
            end else if (!empty) begin
              ddata_d  = rd_word;
              rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
              // A same-cycle write is not forwarded; the strobe underflows.
              ddata_d = '0;
              dunf_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ddata_q  <= '0;
      dunf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ddata_q  <= ddata_d;
      dunf_q   <= dunf_d;
    end
  end

`ifdef DMA_BUF_CYCLIC_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc_q         <= 1'b0;
      end_latched_q <= 1'b0;
      end_addr_q    <= '0;
    end else begin
      cyc_q         <= cyc_d;
      end_latched_q <= end_latched_d;
      end_addr_q    <= end_addr_d;
    end
  end
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_dma_buf.sv
module tb_ad_ip_jesd204_tpl_dac_dma_buf;

  localparam int DW      = 128;
  localparam int AW      = 6;
  localparam int DEPTH   = 64;
  localparam int PREFILL = 16;
`ifdef DMA_BUF_CYCLIC_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          cyclic = 1'b0;
  logic          s_axis_valid = 1'b0;
  logic          s_axis_ready;
  logic [DW-1:0] s_axis_data = '0;
  logic          s_axis_last = 1'b0;
  logic          dac_valid = 1'b0;
  logic [DW-1:0] dac_ddata;
  logic          dac_dunf;
  logic [AW:0]   level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_dma_buf #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PREFILL(PREFILL)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .cyclic(cyclic),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
    .dac_valid(dac_valid), .dac_ddata(dac_ddata), .dac_dunf(dac_dunf),
    .level(level)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a queue of stored words and a playout mode.
  // mst: 0 = idle, 1 = filling, 2 = playing out.
  logic [DW-1:0] mq[$];
  int            mst = 0;
  bit            m_cyc = 1'b0;
  bit            m_endl = 1'b0;
  logic [DW-1:0] m_dd = '0;
  bit            m_dunf = 1'b0;

  function automatic bit m_ready();
    return (mst != 0) && (mq.size() < DEPTH) && !m_endl;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        mq.delete(); mst = 0; m_cyc = 0; m_endl = 0; m_dd = '0; m_dunf = 0;
      end else begin
        bit wr;
        logic [DW-1:0] w;
        wr = s_axis_valid && m_ready();
        m_dunf = 0;
        if (!enable) begin
          mst = 0; mq.delete(); m_dd = '0; m_endl = 0; m_cyc = 0;
        end else if (mst == 0) begin
          mst = 1; m_dd = '0; m_cyc = CYC_EN && cyclic;
        end else begin
          if (mst == 2 && dac_valid) begin
            if (m_cyc) begin
              w = mq.pop_front(); mq.push_back(w); m_dd = w;
            end else if (mq.size() > 0) begin
              m_dd = mq.pop_front();
            end else begin
              m_dd = '0; m_dunf = 1;
            end
          end
          if (wr) mq.push_back(s_axis_data);
          if (mst == 1) begin
            if (m_cyc) begin
              if (wr && (s_axis_last || mq.size() == DEPTH)) begin
                m_endl = 1; mst = 2;
              end
            end else if (mq.size() >= PREFILL || (wr && s_axis_last)) begin
              mst = 2;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      chk("ready", DW'(s_axis_ready), DW'(m_ready()));
      chk("level", DW'(level), DW'(mq.size()));
      chk("ddata", dac_ddata, m_dd);
      chk("dunf", DW'(dac_dunf), DW'(m_dunf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer words first..first+n-1, optionally reading every cycle.
  task automatic push_words(input int first, input int n, input bit last_at_end, input bit rd);
    int k = 0;
    int guard = 0;
    bit acc;
    while (k < n && guard < 500) begin
      s_axis_valid = 1'b1;
      s_axis_data  = DW'(first + k);
      s_axis_last  = last_at_end && (k == n - 1);
      dac_valid    = rd;
      acc          = s_axis_ready;
      tick();
      if (acc) k++;
      guard++;
    end
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
    if (k < n) chk("push_timeout", DW'(k), DW'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    chk("rst_ready", DW'(s_axis_ready), '0);
    chk("rst_ddata", dac_ddata, '0);
    chk("rst_dunf", DW'(dac_dunf), '0);
    chk("rst_level", DW'(level), '0);
    resetn = 1'b1;
    tick();

    // Prefill with continuous strobes, then sequential playout and drain.
    enable = 1'b1;
    push_words(1, 16, 1'b0, 1'b1);
    chk("pf_level16", DW'(level), DW'(16));
    chk("pf_ddata0", dac_ddata, '0);
    tick(); chk("pf_w1", dac_ddata, DW'(1));
    tick(); chk("pf_w2", dac_ddata, DW'(2));
    tick(); chk("pf_w3", dac_ddata, DW'(3));
    repeat (15) tick();
    dac_valid = 1'b0;
    enable = 1'b0;
    tick();

    // Short transfer ending with last, then back-to-back underflow.
    enable = 1'b1;
    push_words(101, 3, 1'b1, 1'b0);
    chk("st_level", DW'(level), DW'(3));
    dac_valid = 1'b1;
    tick(); chk("st_w1", dac_ddata, DW'(101));
    tick(); chk("st_w2", dac_ddata, DW'(102));
    tick(); chk("st_w3", dac_ddata, DW'(103));
    tick(); chk("uf1_data", dac_ddata, '0); chk("uf1_dunf", DW'(dac_dunf), DW'(1));
    tick(); chk("uf2_dunf", DW'(dac_dunf), DW'(1));
    dac_valid = 1'b0;
    tick(); chk("uf_clear", DW'(dac_dunf), '0);
    enable = 1'b0;
    tick();

    // Full: 64 accepted, further words stall, then drain while writing.
    enable = 1'b1;
    push_words(201, 64, 1'b0, 1'b0);
    s_axis_valid = 1'b1;
    s_axis_data  = DW'(265);
    repeat (4) tick();
    chk("full_ready", DW'(s_axis_ready), '0);
    chk("full_level", DW'(level), DW'(64));
    push_words(265, 6, 1'b0, 1'b1);
    chk("rw_level", DW'(level), DW'(63));
    chk("rw_ddata", dac_ddata, DW'(207));
    dac_valid = 1'b1;
    repeat (65) tick();
    dac_valid = 1'b0;
    enable = 1'b0;
    tick();

    // Flush at level 20, then refill from empty.
    enable = 1'b1;
    push_words(301, 21, 1'b0, 1'b0);
    dac_valid = 1'b1;
    tick();
    dac_valid = 1'b0;
    chk("fl_level20", DW'(level), DW'(20));
    chk("fl_ddata", dac_ddata, DW'(301));
    enable = 1'b0;
    tick();
    chk("fl_level0", DW'(level), '0);
    chk("fl_ready0", DW'(s_axis_ready), '0);
    chk("fl_ddata0", dac_ddata, '0);
    enable = 1'b1;
    push_words(401, 2, 1'b1, 1'b0);
    dac_valid = 1'b1;
    tick(); chk("re_w1", dac_ddata, DW'(401));
    dac_valid = 1'b0;

    // Asynchronous reset between clock edges.
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_ddata", dac_ddata, '0);
    chk("ar_level", DW'(level), '0);
    chk("ar_ready", DW'(s_axis_ready), '0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    enable = 1'b0;
    tick();

`ifdef DMA_BUF_CYCLIC_EN
    // Replay of a three-word transfer.
    cyclic = 1'b1;
    enable = 1'b1;
    push_words(501, 3, 1'b1, 1'b0);
    chk("cy_ready", DW'(s_axis_ready), '0);
    dac_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("cy_data", dac_ddata, DW'(501 + (i % 3)));
      chk("cy_dunf", DW'(dac_dunf), '0);
    end
    chk("cy_level", DW'(level), DW'(3));
    dac_valid = 1'b0;
    enable = 1'b0;
    cyclic = 1'b0;
    tick();
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
